// File: rtl/cbud_mod_n.sv
// cbud_mod_n: parametrised synchronous up/down counter with a programmable
// modulus. It has a cascade carry/borrow, synchronous clear, preset and load,
// and optional saturation. It also provides registered terminal-count and
// sticky-wrap flags. Stages chain CAO -> CAI and share CLK, EN and UP.
module cbud_mod_n #(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 0,
  parameter int     SATURATE = 0
) (
  input  logic             CLK,
  input  logic             CDN,
  input  logic             SCLR,
  input  logic             PS,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             EN,
  input  logic             CAI,
  input  logic             UP,
  output logic [WIDTH-1:0] Q,
  output logic             CAO,
  output logic             TC,
  output logic             OVF
);

  // Largest legal count; MODULUS==0 selects the full 2^WIDTH range.
  localparam logic [WIDTH-1:0] CNT_MAX =
    (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);
  localparam bit SAT = (SATURATE != 0);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, ovf_next;

  logic step;
  logic at_max;
  logic at_zero;
  logic below_max;
  logic q_in_range;
  logic d_in_range;
  logic limit;

  // The range tests combine "<" and "==" instead of using "<=". With a full
  // 2^WIDTH modulus, "<= CNT_MAX" would be a constant comparison.
  assign step       = EN & CAI;
  assign at_max     = (q_reg == CNT_MAX);
  assign at_zero    = (q_reg == '0);
  assign below_max  = (q_reg < CNT_MAX);
  assign q_in_range = below_max | at_max;
  assign d_in_range = (D < CNT_MAX) | (D == CNT_MAX);
  assign limit      = UP ? at_max : at_zero;

  // Next-state selection. Priority is SCLR > PS > LD > count > hold.
  // An out-of-range Q can only come from a modulus mismatch. It is pulled
  // back into range by the next step: up goes to 0, down goes to CNT_MAX.
  always_comb begin
    q_next   = q_reg;
    tc_next  = 1'b0;
    ovf_next = ovf_reg;
    if (SCLR) begin
      q_next   = '0;
      ovf_next = 1'b0;
    end else if (PS) begin
      q_next = CNT_MAX;
    end else if (LD) begin
      q_next = d_in_range ? D : CNT_MAX;
    end else if (step) begin
      // A step that meets the limit pulses TC, even if it only holds.
      tc_next = limit;
      if (limit && !SAT) begin
        ovf_next = 1'b1;
      end
      if (UP) begin
        if (at_max) begin
          q_next = SAT ? q_reg : '0;
        end else if (below_max) begin
          q_next = q_reg + WIDTH'(1);
        end else begin
          q_next = '0;
        end
      end else begin
        if (at_zero) begin
          q_next = SAT ? q_reg : CNT_MAX;
        end else if (q_in_range) begin
          q_next = q_reg - WIDTH'(1);
        end else begin
          q_next = CNT_MAX;
        end
      end
    end
  end

  // State registers. CDN clears them immediately, independent of CLK.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      q_reg   <= '0;
      tc_reg  <= 1'b0;
      ovf_reg <= 1'b0;
    end else begin
      q_reg   <= q_next;
      tc_reg  <= tc_next;
      ovf_reg <= ovf_next;
    end
  end

  // Outputs. CAO is zero-latency so that a cascade settles within one cycle.
  // CAO is deliberately not gated by SCLR, PS or LD.
  assign Q   = q_reg;
  assign TC  = tc_reg;
  assign OVF = ovf_reg;
  assign CAO = step & limit;

endmodule

// File: tb/tb_cbud_mod_n.sv
// Testbench for cbud_mod_n. There are three configurations: a 4-bit mod-10
// wrapping counter, a 4-bit full-range saturating counter, and a mod-10 ->
// mod-6 cascade. Stimulus pushes the expected outputs into a scoreboard queue.
// A monitor pops and compares them at each falling edge, or on an explicit
// mid-cycle strobe.
module tb_cbud_mod_n;

  localparam int UA = 0;
  localparam int US = 1;
  localparam int UC = 2;

  typedef struct {
    int         unit;
    logic [7:0] q;
    logic       tc;
    logic       ovf;
    logic       cao;
    logic [1:0] aux;
    string      nm;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mid_strobe = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Unit A: WIDTH=4, MODULUS=10, wrapping.
  logic       cdn_a, sclr_a, ps_a, ld_a, en_a, cai_a, up_a;
  logic [3:0] d_a, q_a;
  logic       cao_a, tc_a, ovf_a;

  // Unit S: WIDTH=4, MODULUS=0, saturating.
  logic       cdn_s, sclr_s, ps_s, ld_s, en_s, cai_s, up_s;
  logic [3:0] d_s, q_s;
  logic       cao_s, tc_s, ovf_s;

  // Cascade: low stage mod 10, high stage mod 6.
  logic       cdn_c, en_c, cai_c, up_c;
  logic       c_zero = 1'b0;
  logic [3:0] c_d = 4'd0;
  logic [3:0] q_lo, q_hi;
  logic       cao_lo, cao_hi, tc_lo, tc_hi, ovf_lo, ovf_hi;

  cbud_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_a (
    .CLK(clk), .CDN(cdn_a), .SCLR(sclr_a), .PS(ps_a), .LD(ld_a), .D(d_a),
    .EN(en_a), .CAI(cai_a), .UP(up_a), .Q(q_a), .CAO(cao_a), .TC(tc_a), .OVF(ovf_a)
  );

  cbud_mod_n #(.WIDTH(4), .MODULUS(0), .SATURATE(1)) dut_s (
    .CLK(clk), .CDN(cdn_s), .SCLR(sclr_s), .PS(ps_s), .LD(ld_s), .D(d_s),
    .EN(en_s), .CAI(cai_s), .UP(up_s), .Q(q_s), .CAO(cao_s), .TC(tc_s), .OVF(ovf_s)
  );

  cbud_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_lo (
    .CLK(clk), .CDN(cdn_c), .SCLR(c_zero), .PS(c_zero), .LD(c_zero), .D(c_d),
    .EN(en_c), .CAI(cai_c), .UP(up_c), .Q(q_lo), .CAO(cao_lo), .TC(tc_lo), .OVF(ovf_lo)
  );

  cbud_mod_n #(.WIDTH(4), .MODULUS(6), .SATURATE(0)) dut_hi (
    .CLK(clk), .CDN(cdn_c), .SCLR(c_zero), .PS(c_zero), .LD(c_zero), .D(c_d),
    .EN(en_c), .CAI(cao_lo), .UP(up_c), .Q(q_hi), .CAO(cao_hi), .TC(tc_hi), .OVF(ovf_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int unit, input int q, input int tc, input int ovf,
                      input int cao, input int aux, input string nm);
    exp_t e;
    e.unit = unit;
    e.q    = 8'(q);
    e.tc   = 1'(tc);
    e.ovf  = 1'(ovf);
    e.cao  = 1'(cao);
    e.aux  = 2'(aux);
    e.nm   = nm;
    sb_q.push_back(e);
  endtask

  task automatic drv_a(input int sclr, input int ps, input int ld, input int d,
                       input int en, input int cai, input int up);
    sclr_a = 1'(sclr); ps_a = 1'(ps); ld_a = 1'(ld); d_a = 4'(d);
    en_a = 1'(en); cai_a = 1'(cai); up_a = 1'(up);
  endtask

  task automatic drv_s(input int sclr, input int ps, input int ld, input int d,
                       input int en, input int cai, input int up);
    sclr_s = 1'(sclr); ps_s = 1'(ps); ld_s = 1'(ld); d_s = 4'(d);
    en_s = 1'(en); cai_s = 1'(cai); up_s = 1'(up);
  endtask

  // Monitor: pop one expectation per sample point and compare it.
  always begin
    exp_t        e;
    logic [12:0] act;
    logic [12:0] expv;
    @(negedge clk or posedge mid_strobe);
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      case (e.unit)
        UA:      act = {4'h0, q_a, tc_a, ovf_a, cao_a, 2'b00};
        US:      act = {4'h0, q_s, tc_s, ovf_s, cao_s, 2'b00};
        default: act = {q_hi, q_lo, tc_hi, ovf_hi, cao_hi, tc_lo, ovf_lo};
      endcase
      expv = {e.q, e.tc, e.ovf, e.cao, e.aux};
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL %s: got q=%0h tc=%0b ovf=%0b cao=%0b aux=%0b, expected q=%0h tc=%0b ovf=%0b cao=%0b aux=%0b",
                 e.nm, act[12:5], act[4], act[3], act[2], act[1:0],
                 e.q, e.tc, e.ovf, e.cao, e.aux);
      end else begin
        $display("check %s: q=%0h tc=%0b ovf=%0b cao=%0b aux=%0b ok",
                 e.nm, act[12:5], act[4], act[3], act[2], act[1:0]);
      end
    end
  end

  initial begin
    cdn_a = 1'b0; cdn_s = 1'b0; cdn_c = 1'b0;
    drv_a(0, 0, 0, 0, 0, 0, 1);
    drv_s(0, 0, 0, 0, 0, 0, 1);
    en_c = 1'b0; cai_c = 1'b0; up_c = 1'b1;

    // Reset state of unit A while CDN is held low.
    tick(); push(UA, 0, 0, 0, 0, 0, "a_reset");
    cdn_s = 1'b1; cdn_c = 1'b1;

    // Release CDN and count up to 7.
    tick(); cdn_a = 1'b1; drv_a(0, 0, 0, 0, 1, 1, 1);
    push(UA, 0, 0, 0, 0, 0, "a_cdn_low_edge");
    for (int k = 1; k <= 7; k++) begin
      tick(); push(UA, k, 0, 0, 0, 0, "a_count");
    end
    en_a = 1'b0;

    // Drop CDN mid-cycle and check the clear before the next rising edge.
    @(negedge clk); #1;
    cdn_a = 1'b0;
    #1;
    push(UA, 0, 0, 0, 0, 0, "a_async_clr");
    mid_strobe = 1'b1; #1; mid_strobe = 1'b0;

    // Release CDN again; the first edge with CDN high steps to 1.
    tick(); cdn_a = 1'b1; drv_a(0, 0, 0, 0, 1, 1, 1);
    push(UA, 0, 0, 0, 0, 0, "a_cdn_release");
    tick(); drv_a(1, 0, 0, 0, 1, 1, 1); push(UA, 1, 0, 0, 0, 0, "a_first_step");
    tick(); drv_a(0, 0, 0, 0, 1, 1, 1); push(UA, 0, 0, 0, 0, 0, "a_sclr_over_step");

    // Modulo-10 up wrap from 0. TC pulses after edge 10 and OVF stays set.
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 11) en_a = 1'b0;
      push(UA, k % 10, (k == 10) ? 1 : 0, (k >= 10) ? 1 : 0,
           ((k % 10) == 9) ? 1 : 0, 0, "a_up_wrap");
    end
    tick(); drv_a(1, 0, 0, 0, 0, 0, 1);  push(UA, 1, 0, 1, 0, 0, "a_ovf_sticky");
    tick(); drv_a(0, 0, 1, 1, 0, 0, 1);  push(UA, 0, 0, 0, 0, 0, "a_sclr_ovf");

    // Down wrap, then a direction change at Q=9.
    tick(); drv_a(0, 0, 0, 0, 1, 1, 0);  push(UA, 1, 0, 0, 0, 0, "a_ld1");
    tick();                              push(UA, 0, 0, 0, 1, 0, "a_down0");
    tick(); drv_a(0, 0, 0, 0, 1, 1, 1);  push(UA, 9, 1, 1, 1, 0, "a_down_wrap_dir_up");
    tick(); drv_a(0, 0, 1, 13, 0, 0, 1); push(UA, 0, 1, 1, 0, 0, "a_up_wrap_after_dir");

    // Priority and clipping.
    tick(); drv_a(0, 1, 1, 3, 0, 0, 1);  push(UA, 9, 0, 1, 0, 0, "a_ld_clip");
    tick(); drv_a(0, 0, 1, 4, 1, 1, 1);  push(UA, 9, 0, 1, 1, 0, "a_ps_over_ld");
    tick(); drv_a(0, 1, 0, 0, 0, 0, 1);  push(UA, 4, 0, 1, 0, 0, "a_ld_over_count");
    tick(); drv_a(1, 1, 0, 0, 1, 1, 1);  push(UA, 9, 0, 1, 1, 0, "a_ps");
    tick(); drv_a(0, 0, 0, 0, 0, 0, 1);  push(UA, 0, 0, 0, 0, 0, "a_sclr_ps_step");

    // Saturating unit: hold at 15 going up and at 0 going down.
    tick(); drv_s(0, 0, 1, 14, 0, 0, 1); push(US, 0, 0, 0, 0, 0, "s_reset_hold");
    tick(); drv_s(0, 0, 0, 0, 1, 1, 1);  push(US, 14, 0, 0, 0, 0, "s_ld14");
    tick();                              push(US, 15, 0, 0, 1, 0, "s_to15");
    tick();                              push(US, 15, 1, 0, 1, 0, "s_hold15_a");
    tick();                              push(US, 15, 1, 0, 1, 0, "s_hold15_b");
    tick(); drv_s(0, 0, 0, 0, 1, 0, 1);  push(US, 15, 1, 0, 0, 0, "s_cai_off");
    tick(); drv_s(0, 0, 1, 1, 0, 1, 0);  push(US, 15, 0, 0, 0, 0, "s_idle");
    tick(); drv_s(0, 0, 0, 0, 1, 1, 0);  push(US, 1, 0, 0, 0, 0, "s_ld1");
    tick();                              push(US, 0, 0, 0, 1, 0, "s_down0");
    tick();                              push(US, 0, 1, 0, 1, 0, "s_hold0_a");
    tick(); drv_s(0, 0, 0, 0, 0, 1, 0);  push(US, 0, 1, 0, 0, 0, "s_hold0_b");
    tick();                              push(US, 0, 0, 0, 0, 0, "s_idle0");

    // Cascade: 60 steps. The pair returns to 00 with one high-stage TC pulse.
    tick(); en_c = 1'b1; cai_c = 1'b1; up_c = 1'b1;
    push(UC, 0, 0, 0, 0, 0, "c_start");
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 60) en_c = 1'b0;
      push(UC, ((k / 10) % 6) * 16 + (k % 10),
           (k == 60) ? 1 : 0, (k == 60) ? 1 : 0, (k == 59) ? 1 : 0,
           (((k % 10) == 0) ? 2 : 0) + ((k >= 10) ? 1 : 0), "c_step");
    end
    tick(); push(UC, 0, 0, 1, 0, 1, "c_done");

    // Drain the scoreboard within a bounded number of cycles.
    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cbud_mod_n.md
# cbud_mod_n

Parametrised synchronous up/down counter with programmable modulus, cascade carry/borrow, synchronous clear/preset/load, optional saturation, and registered terminal-count and sticky-wrap flags. It generalises the fixed 4-bit up counter macro family to arbitrary width, modulus and direction. It sits in the macro behavioural library as the building block for timers, dividers and BCD/modulo-N cascades.

## Interface
- WIDTH, 8, counter width in bits (1..32)
- MODULUS, 0, count modulus; 0 means 2^WIDTH; otherwise 2..2^WIDTH
- SATURATE, 0, 1 = hold at limit instead of wrapping

- CLK  in  1  clock, rising edge
- CDN  in  1  asynchronous active-low clear; single clock, reset asynchronous active-low
- SCLR  in  1  synchronous clear
- PS  in  1  synchronous preset to CNT_MAX
- LD  in  1  synchronous parallel load
- D  in  WIDTH  load data
- EN  in  1  count enable
- CAI  in  1  cascade carry/borrow in
- UP  in  1  direction: 1 up, 0 down
- Q  out  WIDTH  count value
- CAO  out  1  cascade carry/borrow out, combinational
- TC  out  1  registered terminal-count pulse
- OVF  out  1  sticky wrap flag

## Operation
- CNT_MAX = (MODULUS==0) ? 2^WIDTH-1 : MODULUS-1.
- Priority, evaluated per rising CLK edge: SCLR > PS > LD > count > hold.
  - SCLR: Q=0, OVF=0.
  - PS: Q=CNT_MAX.
  - LD: Q=D if D<=CNT_MAX, else Q=CNT_MAX (clip). OVF unchanged.
  - Count step (STEP = EN & CAI): UP=1: Q==CNT_MAX ? (SATURATE ? hold : 0) : Q+1. UP=0: Q==0 ? (SATURATE ? hold : CNT_MAX) : Q-1.
  - Otherwise hold.
- Q never leaves 0..CNT_MAX after any synchronous operation. An out-of-range Q can only arise from a MODULUS mismatch. If it does, an up step goes to 0 and a down step goes to CNT_MAX.
- LIMIT = UP ? (Q==CNT_MAX) : (Q==0).
- CAO = EN & CAI & LIMIT, combinational from current Q/UP/EN/CAI. It is asserted in both wrap and saturate modes, and is not gated by SCLR/PS/LD.
- Cascading: CAO of stage k drives CAI of stage k+1. All stages share CLK, EN and UP.
- WRAP_EV = STEP & LIMIT & ~SCLR & ~PS & ~LD & ~SATURATE.
- TC register: TC <= STEP & LIMIT & ~SCLR & ~PS & ~LD. TC is high for exactly one cycle after an edge at which a count step met the limit, including a saturated hold.
- OVF: set on WRAP_EV; cleared only by SCLR or CDN. If SCLR and WRAP_EV coincide, SCLR wins.
- Arithmetic is modulo CNT_MAX+1; there is no internal WIDTH+1 overflow bit.

## Timing
- CDN low: Q=0, TC=0, OVF=0 immediately, independent of CLK. CAO follows combinationally (0 if UP=1 and CNT_MAX>0; EN&CAI if UP=0).
- CDN deassertion is sampled synchronously. The first count edge is the first rising CLK with CDN high at that edge.
- Latency: Q updates one edge after a command is sampled. TC/OVF update at the same edge as the Q transition they describe. CAO is zero-cycle.
- A direction change takes effect at the next edge. CAO reflects the new UP immediately.
- CDN asserted mid-cascade clears only this stage; other stages are unaffected.
- Simultaneous LD and PS: PS wins. Simultaneous LD and count: LD wins; no TC, no OVF.

## Test plan
- Reset/async: WIDTH=4, MODULUS=10. Count to Q=7, drop CDN mid-cycle -> Q=0, TC=0, OVF=0 before the next edge. Release CDN, then one step -> Q=1.
- Modulo up wrap: MODULUS=10, UP=1, EN=CAI=1 from Q=0 for 10 edges. CAO=1 only while Q=9. Q returns to 0 at edge 10. TC=1 for one cycle after edge 10. OVF=1 and stays set until SCLR.
- Down wrap and direction change: from Q=1 with UP=0, step twice -> Q=0 then Q=9, TC pulse, OVF set. Set UP=1 at Q=9 -> CAO=1 combinationally, next step -> Q=0.
- Saturate: SATURATE=1, MODULUS=0, WIDTH=4. Step up from 14 -> 15, then hold at 15 with CAO=1 and TC pulse on each held step, OVF stays 0. Same behaviour at 0 with UP=0.
- Priority and clipping: MODULUS=10. LD with D=13 -> Q=9. PS+LD -> Q=9. SCLR+PS+step at Q=9 -> Q=0, OVF cleared, no TC.
- Cascade: two stages (4-bit mod 10 low, 4-bit mod 6 high), 60 steps from 00 -> low wraps every 10 steps. High increments only on low's CAO. The pair returns to 00 after 60 steps with a single high-stage TC pulse.
